// File: rtl/counter_monitor_pkg.sv
// Shared types and helpers for counter observers: FSM states, step classes and
// a saturating increment for statistic counters up to 32 bits wide.
package counter_monitor_pkg;

  typedef enum logic {
    IDLE,
    TRACK
  } state_e;

  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DOWN,
    STEP_INIT,
    STEP_ERR
  } step_e;

  localparam int unsigned SAT_MAX_W = 32;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    if (w >= SAT_MAX_W) max_v = '1;
    else                max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/counter_step_classifier.sv
// Combinational classification of one observed counter step (prev -> value),
// modulo 2^BITS, with UP > DOWN > INIT > ERR priority and a wrap flag.
module counter_step_classifier
  import counter_monitor_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS-1:0] i_prev,
  input  logic [BITS-1:0] i_value,
  output step_e           o_step,
  output logic            o_wrap
);

  logic [BITS-1:0] w_inc;
  logic [BITS-1:0] w_dec;

  assign w_inc = i_prev + 1'b1;
  assign w_dec = i_prev - 1'b1;

  // UP and DOWN win over INIT so 1->0 and max->0 keep their step meaning.
  always_comb begin
    o_step = STEP_ERR;
    o_wrap = 1'b0;
    if (i_value == w_inc) begin
      o_step = STEP_UP;
      o_wrap = &i_prev;
    end else if (i_value == w_dec) begin
      o_step = STEP_DOWN;
      o_wrap = ~|i_prev;
    end else if (i_value == '0) begin
      o_step = STEP_INIT;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Reader/checker for an up/down counter value stream. Optional wrap statistics
// are built only when COUNTER_MONITOR_WRAP_CNT_EN is defined (CNT_BITS <= 32).
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned BITS     = 8,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic [BITS-1:0]     i_value,
  output logic                o_dir,
  output logic                o_init,
  output logic                o_wrap,
  output logic                o_err_sticky,
  output logic [CNT_BITS-1:0] o_err_cnt,
  output logic [CNT_BITS-1:0] o_wrap_cnt,
  output logic                o_err_valid,
  input  logic                i_err_ready,
  output logic [BITS-1:0]     o_err_prev,
  output logic [BITS-1:0]     o_err_value
);

  state_e              r_state;
  logic [BITS-1:0]     r_prev;
  logic                r_dir;
  logic                r_init;
  logic                r_wrap;
  logic                r_err_sticky;
  logic [CNT_BITS-1:0] r_err_cnt;
  logic                r_err_valid;
  logic [BITS-1:0]     r_err_prev;
  logic [BITS-1:0]     r_err_value;

  step_e w_step;
  logic  w_step_wrap;
  logic  w_classify;
  logic  w_is_err;
  logic  w_xfer;
  logic  w_load;

  counter_step_classifier #(
    .BITS (BITS)
  ) u_classifier (
    .i_prev  (r_prev),
    .i_value (i_value),
    .o_step  (w_step),
    .o_wrap  (w_step_wrap)
  );

  // Error record handshake: the record transfers on a cycle where
  // o_err_valid && i_err_ready; while valid && !ready the record is frozen and
  // further errors are counted but dropped. A load on a transfer cycle replaces it.
  assign w_classify = i_valid && !i_clear && (r_state == TRACK);
  assign w_is_err   = w_classify && (w_step == STEP_ERR);
  assign w_xfer     = r_err_valid && i_err_ready;
  assign w_load     = w_is_err && (!r_err_valid || i_err_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_dir        <= 1'b0;
      r_init       <= 1'b0;
      r_wrap       <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_err_valid  <= 1'b0;
      r_err_prev   <= '0;
      r_err_value  <= '0;
    end else begin
      r_init <= 1'b0;
      r_wrap <= 1'b0;

      // The pending record survives i_clear; only the handshake moves it.
      if (w_load) begin
        r_err_valid <= 1'b1;
        r_err_prev  <= r_prev;
        r_err_value <= i_value;
      end else if (w_xfer) begin
        r_err_valid <= 1'b0;
      end

      if (i_clear) begin
        r_state      <= IDLE;
        r_prev       <= '0;
        r_dir        <= 1'b0;
        r_err_sticky <= 1'b0;
        r_err_cnt    <= '0;
      end else if (i_valid) begin
        r_prev <= i_value;
        case (r_state)
          IDLE: r_state <= TRACK;
          TRACK: begin
            case (w_step)
              STEP_UP: begin
                r_dir  <= 1'b1;
                r_wrap <= w_step_wrap;
              end
              STEP_DOWN: begin
                r_dir  <= 1'b0;
                r_wrap <= w_step_wrap;
              end
              STEP_INIT: r_init <= 1'b1;
              default: begin
                r_err_sticky <= 1'b1;
                r_err_cnt    <= CNT_BITS'(sat_inc(32'(r_err_cnt), CNT_BITS));
              end
            endcase
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef COUNTER_MONITOR_WRAP_CNT_EN
  logic [CNT_BITS-1:0] r_wrap_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wrap_cnt <= '0;
    end else if (w_classify && w_step_wrap) begin
      r_wrap_cnt <= CNT_BITS'(sat_inc(32'(r_wrap_cnt), CNT_BITS));
    end
  end

  assign o_wrap_cnt = r_wrap_cnt;
`else
  assign o_wrap_cnt = '0;
`endif

  assign o_dir        = r_dir;
  assign o_init       = r_init;
  assign o_wrap       = r_wrap;
  assign o_err_sticky = r_err_sticky;
  assign o_err_cnt    = r_err_cnt;
  assign o_err_valid  = r_err_valid;
  assign o_err_prev   = r_err_prev;
  assign o_err_value  = r_err_value;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: directed scenarios with literal expectations, then
// random sample streams checked every cycle against a behavioural model.
module tb_counter_monitor;

  localparam int BITS     = 8;
  localparam int CNT_BITS = 4;
  localparam int MOD      = 1 << BITS;
  localparam int CMAX     = (1 << CNT_BITS) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                i_clk       = 1'b0;
  logic                i_rst       = 1'b1;
  logic                i_clear     = 1'b0;
  logic                i_valid     = 1'b0;
  logic [BITS-1:0]     i_value     = '0;
  logic                i_err_ready = 1'b0;
  logic                o_dir;
  logic                o_init;
  logic                o_wrap;
  logic                o_err_sticky;
  logic [CNT_BITS-1:0] o_err_cnt;
  logic [CNT_BITS-1:0] o_wrap_cnt;
  logic                o_err_valid;
  logic [BITS-1:0]     o_err_prev;
  logic [BITS-1:0]     o_err_value;

  always #5 i_clk = ~i_clk;

  counter_monitor #(
    .BITS     (BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_valid      (i_valid),
    .i_value      (i_value),
    .o_dir        (o_dir),
    .o_init       (o_init),
    .o_wrap       (o_wrap),
    .o_err_sticky (o_err_sticky),
    .o_err_cnt    (o_err_cnt),
    .o_wrap_cnt   (o_wrap_cnt),
    .o_err_valid  (o_err_valid),
    .i_err_ready  (i_err_ready),
    .o_err_prev   (o_err_prev),
    .o_err_value  (o_err_value)
  );

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_wrap_pulses = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit                m_started = 0;
  bit                m_have_ref, m_dir, m_init, m_wrap, m_sticky, m_ev;
  int                m_prev, m_err_cnt, m_wrap_cnt, m_ep, m_eval;
  logic [2*BITS-1:0] exp_q[$];

  task automatic model_step();
    int d;
    logic [BITS-1:0] p8;
    m_started = 1;
    if (i_rst) begin
      m_have_ref = 0; m_dir = 0; m_init = 0; m_wrap = 0; m_sticky = 0; m_ev = 0;
      m_prev = 0; m_err_cnt = 0; m_wrap_cnt = 0; m_ep = 0; m_eval = 0;
      exp_q.delete();
      return;
    end
    m_init = 0;
    m_wrap = 0;
    if (m_ev && i_err_ready) begin
      m_ev = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (i_clear) begin
      m_have_ref = 0; m_prev = 0; m_dir = 0; m_sticky = 0;
      m_err_cnt = 0; m_wrap_cnt = 0;
    end else if (i_valid) begin
      if (!m_have_ref) begin
        m_have_ref = 1;
      end else begin
        d = (int'(i_value) - m_prev + MOD) % MOD;
        if (d == 1) begin
          m_dir = 1; m_wrap = (m_prev == MOD - 1);
        end else if (d == MOD - 1) begin
          m_dir = 0; m_wrap = (m_prev == 0);
        end else if (i_value == 0) begin
          m_init = 1;
        end else begin
          m_sticky = 1;
          if (m_err_cnt < CMAX) m_err_cnt++;
          if (!m_ev) begin
            m_ev = 1; m_ep = m_prev; m_eval = int'(i_value);
            p8 = BITS'(m_prev);
            exp_q.push_back({p8, i_value});
          end
        end
        if (m_wrap && m_wrap_cnt < CMAX) m_wrap_cnt++;
      end
      m_prev = int'(i_value);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare();
    int exp_wcnt;
`ifdef COUNTER_MONITOR_WRAP_CNT_EN
    exp_wcnt = m_wrap_cnt;
`else
    exp_wcnt = 0;
`endif
    chk("dir",        32'(o_dir),        32'(m_dir));
    chk("init",       32'(o_init),       32'(m_init));
    chk("wrap",       32'(o_wrap),       32'(m_wrap));
    chk("err_sticky", 32'(o_err_sticky), 32'(m_sticky));
    chk("err_cnt",    32'(o_err_cnt),    32'(m_err_cnt));
    chk("wrap_cnt",   32'(o_wrap_cnt),   32'(exp_wcnt));
    chk("err_valid",  32'(o_err_valid),  32'(m_ev));
    if (m_ev) begin
      chk("err_prev",  32'(o_err_prev),  32'(m_ep));
      chk("err_value", 32'(o_err_value), 32'(m_eval));
      if (i_err_ready) begin
        chk("xfer_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("xfer_rec", 32'({o_err_prev, o_err_value}), 32'(exp_q[0]));
      end
    end
    if (o_wrap) n_wrap_pulses++;
  endtask

  initial forever begin
    @(posedge i_clk);
    #1;
    if (m_started) compare();
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic v, input logic [BITS-1:0] val, input logic rdy,
                     input logic clr = 1'b0, input logic rst = 1'b0);
    @(negedge i_clk);
    i_rst = rst; i_valid = v; i_value = val; i_err_ready = rdy; i_clear = clr;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [BITS-1:0] last_v;
    logic [BITS-1:0] val;
    int k;
    last_v = '0;

    repeat (3) @(negedge i_clk);
    chk("rst_flags", 32'({o_dir, o_init, o_wrap, o_err_sticky, o_err_valid}), 32'd0);
    chk("rst_cnts",  32'({o_err_cnt, o_wrap_cnt}), 32'd0);
    chk("rst_rec",   32'({o_err_prev, o_err_value}), 32'd0);

    // counting up from reset
    cyc(1, 8'd0, 0); cyc(1, 8'd1, 0);
    chk("t1_first_no_event", 32'({o_dir, o_init, o_wrap}), 32'd0);
    cyc(1, 8'd2, 0); cyc(1, 8'd3, 0); cyc(0, 8'd0, 0);
    chk("t1_dir_up", 32'(o_dir), 32'd1);
    chk("t1_no_err", 32'(o_err_cnt), 32'd0);

    // up-wrap through 255 -> 0
    cyc(0, 8'd0, 0, 1);
    n_wrap_pulses = 0;
    cyc(1, 8'd254, 0); cyc(1, 8'd255, 0); cyc(1, 8'd0, 0);
    chk("t2_no_wrap_yet", 32'(o_wrap), 32'd0);
    cyc(1, 8'd1, 0);
    chk("t2_wrap_after_0", 32'(o_wrap), 32'd1);
    cyc(0, 8'd0, 0); cyc(0, 8'd0, 0);
    chk("t2_one_pulse", 32'(n_wrap_pulses), 32'd1);
`ifdef COUNTER_MONITOR_WRAP_CNT_EN
    chk("t2_wrap_cnt", 32'(o_wrap_cnt), 32'd1);
`else
    chk("t2_wrap_cnt", 32'(o_wrap_cnt), 32'd0);
`endif

    // down through 1 -> 0 -> 255
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd1, 0); cyc(1, 8'd0, 0); cyc(1, 8'd255, 0);
    chk("t3_1to0_not_init", 32'({o_init, o_wrap, o_dir}), 32'd0);
    cyc(0, 8'd0, 0);
    chk("t3_0to255_wrap", 32'({o_wrap, o_dir}), 32'b10);
    chk("t3_no_err", 32'(o_err_cnt), 32'd0);

    // re-init, then an illegal step
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd10, 0); cyc(1, 8'd11, 0); cyc(1, 8'd0, 0); cyc(0, 8'd0, 0);
    chk("t4_init", 32'(o_init), 32'd1);
    chk("t4_no_err", 32'(o_err_cnt), 32'd0);
    cyc(1, 8'd5, 0); cyc(0, 8'd0, 0);
    chk("t4_err_valid", 32'(o_err_valid), 32'd1);
    chk("t4_err_rec", 32'({o_err_prev, o_err_value}), 32'({8'd0, 8'd5}));
    chk("t4_sticky_cnt", 32'({o_err_sticky, o_err_cnt}), 32'({1'b1, 4'd1}));

    // backpressure: 3 errors while not ready, first record is held
    cyc(0, 8'd0, 1, 1);
    cyc(1, 8'd50, 0); cyc(1, 8'd60, 0); cyc(1, 8'd70, 0); cyc(1, 8'd80, 0);
    cyc(0, 8'd0, 0);
    chk("t5_held_rec", 32'({o_err_prev, o_err_value}), 32'({8'd50, 8'd60}));
    chk("t5_cnt3", 32'(o_err_cnt), 32'd3);
    cyc(0, 8'd0, 1); cyc(0, 8'd0, 0);
    chk("t5_valid_dropped", 32'(o_err_valid), 32'd0);

    // clear mid-stream
    cyc(1, 8'd20, 0); cyc(1, 8'd21, 0); cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd7, 0);
    chk("t6_cleared", 32'({o_err_sticky, o_err_cnt}), 32'd0);
    cyc(1, 8'd9, 0);
    chk("t6_ref_no_event", 32'({o_init, o_wrap, o_err_sticky, o_err_cnt}), 32'd0);
    cyc(0, 8'd0, 1);
    chk("t6_err", 32'({o_err_sticky, o_err_cnt}), 32'({1'b1, 4'd1}));

    // random streams
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: val = last_v + 1'b1;
        4, 5, 6:    val = last_v - 1'b1;
        7:          val = '0;
        8:          val = last_v;
        default:    val = BITS'($urandom_range(0, MOD - 1));
      endcase
      if ($urandom_range(0, 99) < 80) begin
        cyc(1, val, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 999) == 0));
        last_v = val;
      end else begin
        cyc(0, val, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
      end
    end
    cyc(0, 8'd0, 1);
    repeat (3) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Reader side of the up/down counter interface: samples a counter's value bus and reconstructs what the counter did each sample (step up, step down, re-init, wrap).
- Flags illegal steps and reports each one through a valid/ready error record.
- Sits beside any counter instance as a checker, or downstream of it as a consumer of the count stream.

Parameters:
- BITS, 8, width of the observed counter value (>= 2)
- CNT_BITS, 16, width of the wrap and error statistic counters

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_clear  input  1  clears statistics and sticky flag, returns FSM to IDLE
- i_valid  input  1  i_value is a valid sample this cycle
- i_value  input  BITS  observed counter value
- o_dir  output  1  last classified step direction: 1 = up, 0 = down
- o_init  output  1  one-cycle pulse: re-init detected
- o_wrap  output  1  one-cycle pulse: wrap detected
- o_err_sticky  output  1  set on first illegal step, held until clear/reset
- o_err_cnt  output  CNT_BITS  saturating count of illegal steps
- o_wrap_cnt  output  CNT_BITS  saturating count of wraps (see Optional Feature)
- o_err_valid  output  1  error record available
- i_err_ready  input  1  consumer accepts error record
- o_err_prev  output  BITS  previous sample of the offending step
- o_err_value  output  BITS  offending sample

Behaviour:
- Reset (i_rst synchronous, active-high; clock i_clk): all outputs 0; FSM = IDLE; previous-sample register 0.
- FSM states: IDLE (no reference sample), TRACK.
  - IDLE + i_valid: store i_value as prev, go to TRACK, no classification.
  - i_clear: same effect as reset, except any pending error record is kept. i_rst has priority over i_clear.
- Classification in TRACK on i_valid, with P = prev and V = i_value, modulo 2^BITS. Priority order:
  1. UP: V == P+1. Sets o_dir=1. If P == all-ones, pulse o_wrap.
  2. DOWN: V == P-1. Sets o_dir=0. If P == 0, pulse o_wrap.
  3. INIT: V == 0. Pulse o_init. o_dir is unchanged.
  4. ERROR: anything else, including V == P.
- After every classification, prev <= V.
- Corner cases:
  - P=1, V=0 is DOWN, not INIT.
  - P=all-ones, V=0 is UP with wrap, not INIT.
- Latency: o_dir, o_init, o_wrap and the statistics update on the clock edge after the sampled edge (1 cycle). Pulses last exactly one cycle.
- Samples with i_valid=0 are ignored; no timeout.
- ERROR handling:
  - o_err_sticky <= 1.
  - o_err_cnt increments, saturating at all-ones.
  - If no record is pending: load o_err_prev=P, o_err_value=V and assert o_err_valid the next cycle.
  - If a record is already pending (o_err_valid && !i_err_ready): the new record is dropped, but the count still increments.
- Error handshake:
  - Record transfers when o_err_valid && i_err_ready. o_err_valid deasserts the next cycle unless a new error loads in that same cycle; in that case the new record replaces the old one and o_err_valid stays high.
  - o_err_prev/o_err_value are stable while o_err_valid && !i_err_ready.
- o_wrap_cnt increments on each wrap, saturating at all-ones.

Optional Feature:
- Macro: COUNTER_MONITOR_WRAP_CNT_EN.
- Defined: o_wrap_cnt counts wraps as specified.
- Undefined: no wrap-count register is built and o_wrap_cnt is tied to 0. The o_wrap pulse is unaffected.

Decomposition:
- Package counter_monitor_pkg holds:
  - typedef enum state_e {IDLE, TRACK}
  - typedef enum step_e {STEP_UP, STEP_DOWN, STEP_INIT, STEP_ERR}
  - a helper function for saturating increment
- One natural combinational sub-module, counter_step_classifier: inputs P and V, outputs step_e and wrap. Reused by future counter checkers.

Test Plan:
- BITS=8. Reset, then samples 0,1,2,3 -> first sample gives no event; then o_dir=1 and zero errors.
- Samples 254,255,0,1 -> exactly one o_wrap pulse, one cycle after sample 0; o_wrap_cnt=1 with macro, 0 without.
- Samples 1,0,255 -> 1→0 is DOWN with no o_init; 0→255 is DOWN with o_wrap.
- Samples 10,11,0 -> o_init pulse, no error; then 0,5 -> error with o_err_prev=0, o_err_value=5, o_err_sticky=1, o_err_cnt=1.
- Hold i_err_ready=0 and inject 3 errors -> first record held stable, o_err_cnt=3. Raise i_err_ready one cycle -> record transfers and o_err_valid drops.
- Assert i_clear mid-stream, then samples 7,9 -> 7 is a new reference with no event; 9 is an error; statistics were 0 before the error.
